// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM stage: memory-op encodings, access sizes,
// the jal link offset and the EX/MEM register layout.
package mem_stage_pkg;

  localparam logic [2:0] MEMOP_W  = 3'd0;
  localparam logic [2:0] MEMOP_HS = 3'd1;
  localparam logic [2:0] MEMOP_HU = 3'd2;
  localparam logic [2:0] MEMOP_BS = 3'd3;
  localparam logic [2:0] MEMOP_BU = 3'd4;

  localparam logic [31:0] LINK_OFFSET = 32'd8;

  typedef enum logic [1:0] {
    ACC_WORD = 2'd0,
    ACC_HALF = 2'd1,
    ACC_BYTE = 2'd2
  } acc_size_e;

  typedef struct packed {
    logic [31:0] alu;
    logic [31:0] mb;
    logic [4:0]  rd;
    logic        regwrite;
    logic        memwrite;
    logic        memtoreg;
    logic        pctoreg;
    logic [2:0]  memop;
    logic [31:0] pc;
  } exmem_t;

  // Unused encodings 5-7 fall through to word access.
  function automatic acc_size_e memop_size(input logic [2:0] op);
    case (op)
      MEMOP_HS, MEMOP_HU: memop_size = ACC_HALF;
      MEMOP_BS, MEMOP_BU: memop_size = ACC_BYTE;
      default:            memop_size = ACC_WORD;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Execute-to-MEM bus plus the forwarding and writeback results of the MEM stage.
// The execute side (master) drives E_* every cycle; there is no stall, a bubble is all-zero controls.
interface mem_stage_if;
  logic [31:0] E_ALUResult;
  logic [31:0] E_MB;
  logic [4:0]  E_MRD;
  logic        E_RegWrite;
  logic        E_MemWrite;
  logic        E_MemToReg;
  logic        E_PcToReg;
  logic [2:0]  E_MemOp;
  logic [31:0] E_PC;

  logic [4:0]  M_RD;
  logic        M_RegWrite;
  logic [31:0] M_FwdData;
  logic        M_AdErr;
  logic [4:0]  W_RD;
  logic        W_RegWrite;
  logic [31:0] W_WData;

  modport master (
    output E_ALUResult, E_MB, E_MRD, E_RegWrite, E_MemWrite, E_MemToReg,
           E_PcToReg, E_MemOp, E_PC,
    input  M_RD, M_RegWrite, M_FwdData, M_AdErr, W_RD, W_RegWrite, W_WData
  );

  modport slave (
    input  E_ALUResult, E_MB, E_MRD, E_RegWrite, E_MemWrite, E_MemToReg,
           E_PcToReg, E_MemOp, E_PC,
    output M_RD, M_RegWrite, M_FwdData, M_AdErr, W_RD, W_RegWrite, W_WData
  );
endinterface

// File: rtl/mem_stage_dm_ram.sv
// Data memory: DEPTH x 32 words, byte-enable write, combinational read,
// synchronous active-low clear of every word.
module dm_ram #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_we,
  input  logic [3:0]    i_be,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [0:DEPTH-1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_we) begin
      for (int b = 0; b < 4; b++) begin
        if (i_be[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/mem_stage.sv
// MEM stage of the 5-stage MIPS pipeline: EX/MEM register, byte/half/word data
// memory access with alignment checking, and the MEM/WB register.
module mem_stage #(
  parameter int DM_WORDS = 1024,
  parameter int DM_AW    = 10
) (
  input  logic       clk,
  input  logic       reset,
  mem_stage_if.slave bus
);
  import mem_stage_pkg::*;

  exmem_t      r_m;
  exmem_t      w_e;
  logic [4:0]  r_w_rd;
  logic        r_w_regwrite;
  logic [31:0] r_w_wdata;

  acc_size_e   w_size;
  logic [1:0]  w_lo;
  logic        w_misaligned;
  logic        w_aderr;
  logic        w_we;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_rdata;
  logic [15:0] w_half;
  logic [7:0]  w_byte;
  logic [31:0] w_load;
  logic [31:0] w_link;
  logic [31:0] w_wb_data;
  logic [DM_AW-1:0] w_word_idx;

  assign w_e = '{alu:      bus.E_ALUResult,
                 mb:       bus.E_MB,
                 rd:       bus.E_MRD,
                 regwrite: bus.E_RegWrite,
                 memwrite: bus.E_MemWrite,
                 memtoreg: bus.E_MemToReg,
                 pctoreg:  bus.E_PcToReg,
                 memop:    bus.E_MemOp,
                 pc:       bus.E_PC};

  always_ff @(posedge clk) begin
    if (!reset) r_m <= '0;
    else        r_m <= w_e;
  end

  // Upper address bits are dropped, so accesses wrap modulo the memory size.
  assign w_word_idx = r_m.alu[DM_AW+1:2];
  assign w_lo       = r_m.alu[1:0];
  assign w_size     = memop_size(r_m.memop);

  always_comb begin
    w_misaligned = 1'b0;
    w_be         = 4'hF;
    w_wdata      = r_m.mb;
    w_half       = w_lo[1] ? w_rdata[31:16] : w_rdata[15:0];
    w_byte       = w_rdata[{w_lo, 3'b000} +: 8];
    w_load       = w_rdata;
    case (w_size)
      ACC_HALF: begin
        w_misaligned = w_lo[0];
        w_be         = w_lo[1] ? 4'b1100 : 4'b0011;
        w_wdata      = {2{r_m.mb[15:0]}};
        w_load       = (r_m.memop == MEMOP_HS) ? {{16{w_half[15]}}, w_half}
                                               : {16'h0000, w_half};
      end
      ACC_BYTE: begin
        w_be    = 4'b0001 << w_lo;
        w_wdata = {4{r_m.mb[7:0]}};
        w_load  = (r_m.memop == MEMOP_BS) ? {{24{w_byte[7]}}, w_byte}
                                          : {24'h000000, w_byte};
      end
      default: begin
        w_misaligned = (w_lo != 2'b00);
      end
    endcase
  end

  assign w_aderr = (r_m.memwrite | r_m.memtoreg) & w_misaligned;
  assign w_we    = r_m.memwrite & ~w_aderr;

  dm_ram #(
    .DEPTH (DM_WORDS),
    .AW    (DM_AW)
  ) u_dm_ram (
    .clk     (clk),
    .rst_n   (reset),
    .i_we    (w_we),
    .i_be    (w_be),
    .i_addr  (w_word_idx),
    .i_wdata (w_wdata),
    .o_rdata (w_rdata)
  );

  assign w_link    = r_m.pc + LINK_OFFSET;
  assign w_wb_data = r_m.pctoreg  ? w_link :
                     r_m.memtoreg ? w_load : r_m.alu;

  // A misaligned load must not update its destination register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_w_rd       <= '0;
      r_w_regwrite <= 1'b0;
      r_w_wdata    <= '0;
    end else begin
      r_w_rd       <= r_m.rd;
      r_w_regwrite <= r_m.regwrite & ~(r_m.memtoreg & w_aderr);
      r_w_wdata    <= w_wb_data;
    end
  end

  assign bus.M_RD       = r_m.rd;
  assign bus.M_RegWrite = r_m.regwrite;
  assign bus.M_FwdData  = r_m.pctoreg ? w_link : r_m.alu;
  assign bus.M_AdErr    = w_aderr;
  assign bus.W_RD       = r_w_rd;
  assign bus.W_RegWrite = r_w_regwrite;
  assign bus.W_WData    = r_w_wdata;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus a random
// store/load mix against a byte-array memory model.
module tb_mem_stage;

  localparam logic [2:0] OP_W  = 3'd0;
  localparam logic [2:0] OP_HS = 3'd1;
  localparam logic [2:0] OP_HU = 3'd2;
  localparam logic [2:0] OP_BS = 3'd3;
  localparam logic [2:0] OP_BU = 3'd4;

  logic clk;
  logic reset;
  logic stim_valid;
  int   total;
  int   bad;
  bit   v_m;
  bit   v_w;
  logic [37:0] exp_q[$];
  logic [7:0]  mdl [0:255];

  mem_stage_if bus();

  mem_stage #(
    .DM_WORDS (1024),
    .DM_AW    (10)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Writeback scoreboard: an op driven before edge n reaches W after edge n+1.
  always begin
    logic cap;
    logic rst_s;
    logic [37:0] e;
    @(posedge clk);
    cap   = stim_valid;
    rst_s = reset;
    #1;
    v_w = v_m & rst_s;
    v_m = cap & rst_s;
    if (v_w) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL wb_unexpected: got rw=%0b rd=%0d data=%h, no op expected",
                 bus.W_RegWrite, bus.W_RD, bus.W_WData);
      end else begin
        e = exp_q.pop_front();
        if ({bus.W_RegWrite, bus.W_RD, bus.W_WData} !== e) begin
          bad++;
          $display("FAIL wb: got rw=%0b rd=%0d data=%h, expected rw=%0b rd=%0d data=%h",
                   bus.W_RegWrite, bus.W_RD, bus.W_WData, e[37], e[36:32], e[31:0]);
        end
      end
    end
  end

  task automatic drive_zero();
    bus.E_ALUResult = '0; bus.E_MB = '0; bus.E_MRD = '0;
    bus.E_RegWrite = 1'b0; bus.E_MemWrite = 1'b0; bus.E_MemToReg = 1'b0;
    bus.E_PcToReg = 1'b0; bus.E_MemOp = '0; bus.E_PC = '0;
    stim_valid = 1'b0;
  endtask

  task automatic bubble(input int n);
    repeat (n) begin
      @(negedge clk);
      drive_zero();
    end
  endtask

  task automatic issue(input logic [31:0] alu, input logic [31:0] mb, input logic [4:0] rd,
                       input logic rw, input logic mw, input logic m2r, input logic p2r,
                       input logic [2:0] op, input logic [31:0] pc, input logic [37:0] exp_w);
    @(negedge clk);
    bus.E_ALUResult = alu; bus.E_MB = mb; bus.E_MRD = rd;
    bus.E_RegWrite = rw; bus.E_MemWrite = mw; bus.E_MemToReg = m2r;
    bus.E_PcToReg = p2r; bus.E_MemOp = op; bus.E_PC = pc;
    stim_valid = 1'b1;
    exp_q.push_back(exp_w);
  endtask

  task automatic st(input logic [31:0] addr, input logic [31:0] data, input logic [2:0] op);
    issue(addr, data, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, op, 32'h0, {1'b0, 5'd0, addr});
  endtask

  task automatic ld(input logic [31:0] addr, input logic [2:0] op, input logic [4:0] rd,
                    input logic [31:0] exp_data, input logic exp_rw);
    issue(addr, 32'h0, rd, 1'b1, 1'b0, 1'b1, 1'b0, op, 32'h0, {exp_rw, rd, exp_data});
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b0;
    drive_zero();
    repeat (2) @(negedge clk);
    total++;
    if ({bus.M_RD, bus.M_RegWrite, bus.M_FwdData, bus.M_AdErr} !== 39'h0) begin
      bad++;
      $display("FAIL reset_m: got rd=%0d rw=%0b fwd=%h aderr=%0b, expected all 0",
               bus.M_RD, bus.M_RegWrite, bus.M_FwdData, bus.M_AdErr);
    end
    total++;
    if ({bus.W_RD, bus.W_RegWrite, bus.W_WData} !== 38'h0) begin
      bad++;
      $display("FAIL reset_w: got rd=%0d rw=%0b data=%h, expected all 0",
               bus.W_RD, bus.W_RegWrite, bus.W_WData);
    end
    reset = 1'b1;
    ld(32'h0,   OP_W, 5'd1, 32'h0, 1'b1);
    ld(32'hFFC, OP_W, 5'd2, 32'h0, 1'b1);
    bubble(2);
  endtask

  task automatic test_word_bytes();
    st(32'h10, 32'h12345678, OP_W);
    ld(32'h11, OP_BS, 5'd1, 32'h00000056, 1'b1);
    ld(32'h13, OP_BS, 5'd2, 32'h00000012, 1'b1);
    ld(32'h13, OP_BU, 5'd3, 32'h00000012, 1'b1);
    ld(32'h10, OP_HS, 5'd4, 32'h00005678, 1'b1);
    ld(32'h12, OP_HU, 5'd5, 32'h00001234, 1'b1);
    st(32'h14, 32'h80FF7F01, OP_W);
    ld(32'h15, OP_BS, 5'd6, 32'h0000007F, 1'b1);
    ld(32'h16, OP_BS, 5'd7, 32'hFFFFFFFF, 1'b1);
    ld(32'h16, OP_BU, 5'd8, 32'h000000FF, 1'b1);
    ld(32'h16, OP_HS, 5'd9, 32'hFFFF80FF, 1'b1);
    bubble(2);
  endtask

  task automatic test_sub_word_stores();
    st(32'h22, 32'hABCDEFFF, OP_BU);
    ld(32'h22, OP_HS, 5'd1, 32'h000000FF, 1'b1);
    ld(32'h22, OP_HU, 5'd2, 32'h000000FF, 1'b1);
    ld(32'h20, OP_W,  5'd3, 32'h00FF0000, 1'b1);
    st(32'h6, 32'h12348001, OP_HU);
    ld(32'h6, OP_HS, 5'd4, 32'hFFFF8001, 1'b1);
    ld(32'h6, OP_HU, 5'd5, 32'h00008001, 1'b1);
    ld(32'h7, OP_BS, 5'd6, 32'hFFFFFF80, 1'b1);
    ld(32'h4, OP_W,  5'd7, 32'h80010000, 1'b1);
    bubble(2);
  endtask

  task automatic test_misaligned();
    st(32'h2, 32'hAABBCCDD, OP_W);
    @(posedge clk); #2;
    total++;
    if (bus.M_AdErr !== 1'b1) begin
      bad++; $display("FAIL aderr_sw: got %0b, expected 1", bus.M_AdErr);
    end
    ld(32'h1, OP_HS, 5'd9, 32'h0, 1'b0);
    @(posedge clk); #2;
    total++;
    if (bus.M_AdErr !== 1'b1) begin
      bad++; $display("FAIL aderr_lh: got %0b, expected 1", bus.M_AdErr);
    end
    ld(32'h0, OP_W, 5'd10, 32'h0, 1'b1);
    @(posedge clk); #2;
    total++;
    if (bus.M_AdErr !== 1'b0) begin
      bad++; $display("FAIL aderr_lw_ok: got %0b, expected 0", bus.M_AdErr);
    end
    ld(32'h11, 3'd5, 5'd11, 32'h12345678, 1'b0);
    ld(32'h10, 3'd6, 5'd12, 32'h12345678, 1'b1);
    ld(32'h3,  3'd7, 5'd13, 32'h0, 1'b0);
    ld(32'h23, OP_BU, 5'd14, 32'h0, 1'b1);
    bubble(2);
  endtask

  task automatic test_alu_jal();
    issue(32'hDEADBEEF, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, OP_W, 32'h100,
          {1'b1, 5'd5, 32'hDEADBEEF});
    @(posedge clk); #2;
    total++;
    if ({bus.M_FwdData, bus.M_RD, bus.M_RegWrite, bus.M_AdErr} !== {32'hDEADBEEF, 5'd5, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL fwd_alu: got fwd=%h rd=%0d rw=%0b aderr=%0b, expected DEADBEEF/5/1/0",
               bus.M_FwdData, bus.M_RD, bus.M_RegWrite, bus.M_AdErr);
    end
    issue(32'h13, 32'h0, 5'd31, 1'b1, 1'b0, 1'b0, 1'b1, OP_W, 32'h3000,
          {1'b1, 5'd31, 32'h3008});
    @(posedge clk); #2;
    total++;
    if (bus.M_FwdData !== 32'h3008) begin
      bad++; $display("FAIL fwd_jal: got %h, expected 00003008", bus.M_FwdData);
    end
    issue(32'h55, 32'h0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, OP_W, 32'h0, {1'b1, 5'd0, 32'h55});
    issue(32'h0, 32'h0, 5'd31, 1'b1, 1'b0, 1'b1, 1'b1, OP_W, 32'h4000,
          {1'b1, 5'd31, 32'h4008});
    bubble(2);
  endtask

  task automatic test_wrap();
    st(32'hFFC, 32'h11223344, OP_W);
    ld(32'hFFC, OP_W, 5'd1, 32'h11223344, 1'b1);
    st(32'h1030, 32'hA5A55A5A, OP_W);
    ld(32'h30, OP_W, 5'd2, 32'hA5A55A5A, 1'b1);
    ld(32'h2FFC, OP_W, 5'd3, 32'h11223344, 1'b1);
    bubble(2);
  endtask

  task automatic test_reset_mid();
    issue(32'h77, 32'h0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, OP_W, 32'h0, {1'b1, 5'd7, 32'h77});
    st(32'h40, 32'hCAFEF00D, OP_W);
    @(negedge clk);
    reset = 1'b0;
    drive_zero();
    @(posedge clk); #2;
    exp_q.delete();
    total++;
    if ({bus.M_RegWrite, bus.W_RegWrite, bus.W_WData, bus.M_AdErr} !== 35'h0) begin
      bad++;
      $display("FAIL reset_mid: got mrw=%0b wrw=%0b wdata=%h aderr=%0b, expected all 0",
               bus.M_RegWrite, bus.W_RegWrite, bus.W_WData, bus.M_AdErr);
    end
    @(negedge clk);
    reset = 1'b1;
    ld(32'h40, OP_W, 5'd3, 32'h0, 1'b1);
    ld(32'h10, OP_W, 5'd4, 32'h0, 1'b1);
    bubble(2);
  endtask

  function automatic void mdl_write(input logic [7:0] a, input logic [31:0] d, input logic [2:0] op);
    if (op == OP_HS || op == OP_HU) begin
      mdl[a] = d[7:0]; mdl[a+8'd1] = d[15:8];
    end else if (op == OP_BS || op == OP_BU) begin
      mdl[a] = d[7:0];
    end else begin
      mdl[a] = d[7:0]; mdl[a+8'd1] = d[15:8]; mdl[a+8'd2] = d[23:16]; mdl[a+8'd3] = d[31:24];
    end
  endfunction

  function automatic logic [31:0] mdl_read(input logic [7:0] a, input logic [2:0] op);
    logic [15:0] h;
    logic [7:0]  b;
    h = {mdl[a+8'd1], mdl[a]};
    b = mdl[a];
    case (op)
      OP_HS:   mdl_read = {{16{h[15]}}, h};
      OP_HU:   mdl_read = {16'h0, h};
      OP_BS:   mdl_read = {{24{b[7]}}, b};
      OP_BU:   mdl_read = {24'h0, b};
      default: mdl_read = {mdl[a+8'd3], mdl[a+8'd2], mdl[a+8'd1], mdl[a]};
    endcase
  endfunction

  task automatic test_random();
    logic [2:0]  op;
    logic [7:0]  off;
    logic [31:0] d;
    for (int i = 0; i < 256; i++) mdl[i] = 8'h0;
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 4));
      if (op == OP_W)                       off = 8'($urandom_range(0, 63) * 4);
      else if (op == OP_HS || op == OP_HU)  off = 8'($urandom_range(0, 127) * 2);
      else                                  off = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom;
        mdl_write(off, d, op);
        st({24'h000002, off}, d, op);
      end else begin
        ld({24'h000002, off}, op, 5'($urandom_range(1, 31)), mdl_read(off, op), 1'b1);
      end
    end
    bubble(2);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    v_m   = 1'b0;
    v_w   = 1'b0;
    reset = 1'b0;
    drive_zero();
    test_reset();
    test_word_bytes();
    test_sub_word_stores();
    test_misaligned();
    test_alu_jal();
    test_wrap();
    test_reset_mid();
    test_random();
    bubble(3);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending writebacks, expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Consumer end of the execute-stage interface in the 5-stage MIPS pipeline.
- Holds the EX/MEM pipeline register and the data memory with byte, half and word access.
- Holds the MEM/WB pipeline register and selects the final writeback value.
- Takes the ALU result, store data and destination register from execute, and drives forwarding and writeback information for the hazard unit and register file.

Parameters:
- DM_WORDS, 1024, data-memory depth in 32-bit words (power of two).
- DM_AW, 10, word-index width; must equal log2(DM_WORDS).

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset.
- E_ALUResult  in  32  execute ALU result; memory byte address for loads/stores.
- E_MB  in  32  execute store data (rt value).
- E_MRD  in  5  execute destination register number.
- E_RegWrite  in  1  instruction writes a register.
- E_MemWrite  in  1  instruction is a store.
- E_MemToReg  in  1  instruction is a load.
- E_PcToReg  in  1  jal-type; writeback value is PC+8.
- E_MemOp  in  3  access type: 0 word, 1 half signed, 2 half unsigned, 3 byte signed, 4 byte unsigned.
- E_PC  in  32  instruction PC.
- M_RD  out  5  destination register held in MEM, for forwarding.
- M_RegWrite  out  1  MEM-stage write enable, for forwarding.
- M_FwdData  out  32  forwardable MEM value: PC+8 if PcToReg, else ALU result.
- M_AdErr  out  1  misaligned access in MEM stage (combinational from M registers).
- W_RD  out  5  writeback register number.
- W_RegWrite  out  1  writeback enable.
- W_WData  out  32  writeback data.

Behaviour:
- Reset (reset==0 at a rising edge):
  - All EX/MEM and MEM/WB registers clear to 0.
  - All outputs read 0.
  - Every memory word clears to 0.
  - A store pending in MEM at that edge is suppressed.
- EX/MEM register: every non-reset edge captures all E_* inputs into M_* registers. No stall input; a bubble is indicated by the E_ control bits being 0.
- Address: word index = M_ALUResult[DM_AW+1:2]. Higher address bits are ignored, so addresses wrap modulo 4*DM_WORDS.
- Alignment: word access needs addr[1:0]==0; half access needs addr[0]==0; byte access is always aligned.
  - M_AdErr = (M_MemWrite|M_MemToReg) & misaligned.
  - Misaligned store: memory is not written.
  - Misaligned load: the destination register is not written (W_RegWrite=0 captured).
- Store:
  - Occurs at the rising edge ending the MEM cycle when M_MemWrite & !M_AdErr.
  - Word: writes all 4 bytes.
  - Half: writes M_MB[15:0] to byte lanes {addr[1],0} and {addr[1],1}.
  - Byte: writes M_MB[7:0] to lane addr[1:0]. Other lanes are unchanged.
  - Little-endian: lane 0 = bits 7:0.
- Load:
  - Combinational read of the indexed word during the MEM cycle.
  - Lane extraction: half from bits [16*addr[1]+:16]; byte from [8*addr[1:0]+:8].
  - Sign- or zero-extended per MemOp.
  - MemOp values 5–7 behave as word.
- MEM/WB register:
  - W_RD = M_RD.
  - W_RegWrite = M_RegWrite & !(M_MemToReg & M_AdErr).
  - W_WData selection, in priority order:
    - M_PcToReg: M_PC+8.
    - M_MemToReg: extended load data.
    - Otherwise: M_ALUResult.
- Latency:
  - An instruction presented on E_* at edge n is visible on M_* after edge n.
  - It is visible on W_* after edge n+1.
- Store followed immediately by load to the same word: the load, in MEM one cycle later, sees the updated data. No extra bypass is needed.
- Register 0: W_RegWrite passes through unchanged. Suppressing writes to $0 is the register file's job.
- Reset asserted mid-sequence: in-flight instructions in MEM and WB are discarded. Reset has priority over capture.

Decomposition:
- Shared package/header holds:
  - MemOp encodings (MEMOP_W, MEMOP_HS, MEMOP_HU, MEMOP_BS, MEMOP_BU).
  - The PC+8 link offset constant.
- One sub-module, dm_ram, containing:
  - DM_WORDS x 32 storage.
  - 4-bit byte-enable write port.
  - Combinational read.
  - Synchronous active-low clear.
- The lane/byte-enable generation and load extension stay in mem_stage.

Test Plan:
- Reset held 2 cycles, then released -> all W_* and M_* outputs are 0; loads from addresses 0x0 and 0xFFC return 0.
- Store word 0x12345678 to address 0x10, then lb (MemOp=3) on 0x11/0x13, then lbu (MemOp=4) on 0x13 -> W_WData = 0x00000056, 0x00000012, 0x00000012.
- Store byte 0xFF to address 0x22 (word 0x20 initially 0), then lh (MemOp=1) on 0x22 and lhu (MemOp=2) on 0x22 -> W_WData = 0x000000FF for both; a word load at 0x20 returns 0x00FF0000.
- Store half 0x8001 to 0x6, then lh on 0x6 -> 0xFFFF8001; lhu on 0x6 -> 0x00008001.
- Word store to address 0x2, then lh on 0x1 -> M_AdErr=1 in each MEM cycle; memory is unchanged; the load has W_RegWrite=0.
- Non-memory ALU op with E_ALUResult=0xDEADBEEF, E_MRD=5, E_RegWrite=1, followed by jal with E_PC=0x3000 and E_PcToReg=1 -> M_FwdData=0xDEADBEEF, then W_WData=0xDEADBEEF/W_RD=5, then W_WData=0x3008.
